regfile_wr_arbiter: RTL

- Shares the register file's single write port between two requesters.
- Requester A is the main pipeline writeback. It has priority and is never back-pressured.
- Requester B is the long-latency unit (divider / late load return). It uses a valid/ready handshake and is buffered in a small FIFO that drains on idle write slots.
- Also flags decode-stage reads of registers with pending B writes, and forces a pipeline bubble when B starves.

---
 rtl/regfile_wr_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port shared by the main pipeline writeback (priority)
// and a FIFO-buffered long-latency requester, with pending-write hazard flags.
module regfile_wr_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        pend_hit1,
    output logic        pend_hit2
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_FORCE} state_t;

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_occ;
    logic [CW-1:0]    r_starve;
    state_t           r_state;

    logic             w_a_act;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_blocked;
    logic [AW:0]      w_occ_nxt;
    logic [CW-1:0]    w_starve_inc;
    logic [CW-1:0]    w_starve_nxt;
    state_t           w_state_nxt;
    logic             w_hit1;
    logic             w_hit2;

    assign w_a_act      = wb_we && (wb_waddr != 5'd0);
    assign w_empty      = (r_occ == '0);
    assign w_full       = (r_occ == (AW+1)'(DEPTH));
    assign w_push       = b_valid && !w_full;
    assign w_pop        = !w_a_act && !w_empty;
    assign w_blocked    = w_a_act && !w_empty;
    assign w_occ_nxt    = r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_starve_inc = r_starve + 1'b1;

    assign b_ready   = !rst && !w_full;
    assign stall_req = (r_state == S_FORCE);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (w_a_act) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (!w_empty) begin
                rf_we    = r_live[r_rd];
                rf_waddr = r_addr[r_rd];
                rf_wdata = r_data[r_rd];
            end
        end
    end

    // Conservative: an entry draining this cycle still reports a hit.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_addr[i] == raddr1)) w_hit1 = 1'b1;
            if (r_live[i] && (r_addr[i] == raddr2)) w_hit2 = 1'b1;
        end
    end

    assign pend_hit1 = w_hit1 && (raddr1 != 5'd0);
    assign pend_hit2 = w_hit2 && (raddr2 != 5'd0);

    // Payload storage carries no reset; validity lives in r_live and r_occ.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr] <= b_waddr;
            r_data[r_wr] <= b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_occ  <= '0;
            r_live <= '0;
        end else begin
            // WAW kill first so a same-cycle push (newer than A) keeps its live bit.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_a_act && (r_addr[i] == wb_waddr)) r_live[i] <= 1'b0;
            end
            if (w_pop) begin
                r_live[r_rd] <= 1'b0;
                r_rd         <= r_rd + 1'b1;
            end
            if (w_push) begin
                r_live[r_wr] <= (b_waddr != 5'd0);
                r_wr         <= r_wr + 1'b1;
            end
            r_occ <= w_occ_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        case (r_state)
            S_IDLE: begin
                w_starve_nxt = '0;
                if (w_push) w_state_nxt = S_PEND;
            end
            S_PEND: begin
                if (w_pop) begin
                    w_starve_nxt = '0;
                    if (w_occ_nxt == '0) w_state_nxt = S_IDLE;
                end else if (w_blocked) begin
                    w_starve_nxt = w_starve_inc;
                    if (w_starve_inc >= CW'(STARVE_MAX)) w_state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                // If the pipeline ignores the stall, A wins and the forced drain waits.
                if (w_pop) begin
                    w_starve_nxt = '0;
                    w_state_nxt  = (w_occ_nxt == '0) ? S_IDLE : S_PEND;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_starve_nxt = '0;
            end
        endcase
    end

endmodule
